// File: rtl/adc_buf_pkg.sv
// Shared types and default widths for the ADC sample-buffer controller.
package adc_buf_pkg;

   localparam int ADDR_W_DEF = 10;
   localparam int DATA_W_DEF = 16;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ARM     = 3'd1,
      CAPTURE = 3'd2,
      READOUT = 3'd3,
      DONE    = 3'd4
   } state_t;

endpackage

// File: rtl/adc_buf_skid.sv
// Two-entry output buffer: absorbs the one-cycle BRAM read latency so the
// stream can run one beat per clock while the consumer is ready.
module adc_buf_skid
   import adc_buf_pkg::*;
#(
   parameter int W = 17
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         s_valid,
   input  logic [W-1:0] s_data,
   output logic         s_ready,
   output logic         m_valid,
   output logic [W-1:0] m_data,
   input  logic         m_ready
);

   logic [1:0]   r_cnt;
   logic [W-1:0] r_head;
   logic [W-1:0] r_tail;
   logic         w_push;
   logic         w_pop;

   // Valid/ready on both sides: a beat moves on a clock edge where valid and
   // ready are both high; once valid is raised the data holds until accepted.
   assign s_ready = (r_cnt != 2'd2);
   assign m_valid = (r_cnt != 2'd0);
   assign m_data  = r_head;
   assign w_push  = s_valid && s_ready;
   assign w_pop   = m_valid && m_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt  <= 2'd0;
         r_head <= '0;
         r_tail <= '0;
      end else if (flush) begin
         r_cnt <= 2'd0;
      end else begin
         case ({w_push, w_pop})
            2'b11: begin
               if (r_cnt == 2'd2) begin
                  r_head <= r_tail;
                  r_tail <= s_data;
               end else begin
                  r_head <= s_data;
               end
            end
            2'b01: begin
               r_head <= r_tail;
               r_cnt  <= r_cnt - 2'd1;
            end
            2'b10: begin
               if (r_cnt == 2'd0) r_head <= s_data;
               else               r_tail <= s_data;
               r_cnt <= r_cnt + 2'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/adc_buf_ctrl.sv
// Sequences the ADC sample BRAM: arm, trigger, capture one frame, stream it out.
// Optional decimation in CAPTURE is enabled with the ADC_BUF_DECIM_EN macro.
module adc_buf_ctrl
   import adc_buf_pkg::*;
#(
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter int DATA_W    = DATA_W_DEF,
   parameter int FRAME_LEN = 1024
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic              trig,
   input  logic              adc_valid,
   input  logic [DATA_W-1:0] adc_data,
`ifdef ADC_BUF_DECIM_EN
   input  logic [3:0]        decim,
`endif
   output logic              ram_cea,
   output logic [ADDR_W-1:0] ram_ada,
   output logic [DATA_W-1:0] ram_din,
   output logic              ram_ceb,
   output logic [ADDR_W-1:0] ram_adb,
   output logic              ram_oce,
   input  logic [DATA_W-1:0] ram_dout,
   output logic              m_valid,
   output logic [DATA_W-1:0] m_data,
   output logic              m_last,
   input  logic              m_ready,
   output logic              busy,
   output logic              done,
   output logic              ovf,
   output state_t            dbg_state
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);
   localparam logic [ADDR_W:0]   FRAME_CNT = (ADDR_W + 1)'(FRAME_LEN);

   state_t              r_state;
   logic [ADDR_W-1:0]   r_wr_ptr;
   logic [ADDR_W:0]     r_rd_ptr;
   logic                r_cea;
   logic [ADDR_W-1:0]   r_ada;
   logic [DATA_W-1:0]   r_din;
   logic                r_pend;
   logic                r_pend_last;
   logic                r_done;
   logic                r_ovf;
   logic                w_take;
   logic                w_space;
   logic                w_ceb;
   logic                w_pop;
   logic                w_sk_ready;
   logic                w_sk_valid;
   logic [DATA_W:0]     w_sk_data;

`ifdef ADC_BUF_DECIM_EN
   logic [3:0]          r_dcnt;
   assign w_take = (r_dcnt == decim);
`else
   assign w_take = 1'b1;
`endif

   // A read may issue only if the buffer can still hold it after the read
   // already in flight lands, counting a beat leaving this cycle.
   assign w_pop   = w_sk_valid && m_ready;
   assign w_space = r_pend ? (!w_sk_valid || (w_sk_ready && w_pop))
                           : (w_sk_ready || w_pop);
   assign w_ceb   = !abort && (r_state == READOUT) && (r_rd_ptr != FRAME_CNT) && w_space;

   assign ram_cea   = r_cea;
   assign ram_ada   = r_ada;
   assign ram_din   = r_din;
   assign ram_ceb   = w_ceb;
   assign ram_adb   = w_ceb ? r_rd_ptr[ADDR_W-1:0] : '0;
   assign ram_oce   = 1'b1;
   assign m_valid   = w_sk_valid;
   assign m_data    = w_sk_data[DATA_W-1:0];
   assign m_last    = w_sk_data[DATA_W];
   assign busy      = (r_state != IDLE);
   assign done      = r_done;
   assign ovf       = r_ovf;
   assign dbg_state = r_state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_cea       <= 1'b0;
         r_ada       <= '0;
         r_din       <= '0;
         r_pend      <= 1'b0;
         r_pend_last <= 1'b0;
         r_done      <= 1'b0;
         r_ovf       <= 1'b0;
`ifdef ADC_BUF_DECIM_EN
         r_dcnt      <= '0;
`endif
      end else begin
         r_cea       <= 1'b0;
         r_done      <= 1'b0;
         r_pend      <= w_ceb;
         r_pend_last <= w_ceb && (r_rd_ptr[ADDR_W-1:0] == LAST_ADDR);
         if (w_ceb) r_rd_ptr <= r_rd_ptr + 1'b1;
         if (abort) begin
            r_state <= IDLE;
            r_pend  <= 1'b0;
         end else begin
            case (r_state)
               IDLE: begin
                  if (start) begin
                     r_state  <= ARM;
                     r_wr_ptr <= '0;
                     r_rd_ptr <= '0;
                     r_ovf    <= 1'b0;
                  end
               end
               ARM: begin
                  if (adc_valid && trig) begin
                     r_cea    <= 1'b1;
                     r_ada    <= '0;
                     r_din    <= adc_data;
                     r_wr_ptr <= ADDR_W'(1);
                     r_state  <= CAPTURE;
`ifdef ADC_BUF_DECIM_EN
                     r_dcnt   <= '0;
`endif
                  end
               end
               CAPTURE: begin
                  if (adc_valid && w_take) begin
                     r_cea <= 1'b1;
                     r_ada <= r_wr_ptr;
                     r_din <= adc_data;
                     if (r_wr_ptr == LAST_ADDR) r_state  <= READOUT;
                     else                       r_wr_ptr <= r_wr_ptr + 1'b1;
                  end
`ifdef ADC_BUF_DECIM_EN
                  if (adc_valid) r_dcnt <= w_take ? 4'd0 : r_dcnt + 4'd1;
`endif
               end
               READOUT: begin
                  if (adc_valid) r_ovf <= 1'b1;
                  if (w_pop && m_last) begin
                     r_state <= DONE;
                     r_done  <= 1'b1;
                  end
               end
               DONE:    r_state <= IDLE;
               default: r_state <= IDLE;
            endcase
         end
      end
   end

   adc_buf_skid #(.W(DATA_W + 1)) u_skid (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush   (abort),
      .s_valid (r_pend),
      .s_data  ({r_pend_last, ram_dout}),
      .s_ready (w_sk_ready),
      .m_valid (w_sk_valid),
      .m_data  (w_sk_data),
      .m_ready (m_ready)
   );

endmodule

// File: tb/tb_adc_buf_ctrl.sv
// Scoreboard bench for adc_buf_ctrl: a frame-level reference model predicts
// BRAM writes and stream beats; monitors compare what the DUT presents.
module tb_adc_buf_ctrl;
   import adc_buf_pkg::*;

   localparam int AW = 10;
   localparam int DW = 16;
   localparam int FL = 1024;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic          trig = 1'b0;
   logic          adc_valid = 1'b0;
   logic [DW-1:0] adc_data = '0;
   logic          ram_cea, ram_ceb, ram_oce;
   logic [AW-1:0] ram_ada, ram_adb;
   logic [DW-1:0] ram_din;
   logic [DW-1:0] ram_dout;
   logic          m_valid, m_last, busy, done, ovf;
   logic [DW-1:0] m_data;
   logic          m_ready = 1'b1;
   state_t        dbg_state;
`ifdef ADC_BUF_DECIM_EN
   logic [3:0]    decim = 4'd0;
`endif

   always #5 clk = ~clk;

   adc_buf_ctrl #(.ADDR_W(AW), .DATA_W(DW), .FRAME_LEN(FL)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .trig(trig),
      .adc_valid(adc_valid), .adc_data(adc_data),
`ifdef ADC_BUF_DECIM_EN
      .decim(decim),
`endif
      .ram_cea(ram_cea), .ram_ada(ram_ada), .ram_din(ram_din),
      .ram_ceb(ram_ceb), .ram_adb(ram_adb), .ram_oce(ram_oce), .ram_dout(ram_dout),
      .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
      .busy(busy), .done(done), .ovf(ovf), .dbg_state(dbg_state)
   );

   // Simple-dual-port BRAM, registered read, output register bypassed.
   logic [DW-1:0] mem [0:(1<<AW)-1];
   always @(posedge clk) begin
      if (ram_cea) mem[ram_ada] <= ram_din;
      if (ram_ceb) ram_dout <= mem[ram_adb];
   end

   // ---------------- scoreboard ----------------
   logic [DW:0]    exp_q[$];
   logic [AW+DW-1:0] exp_wr_q[$];
   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   int   mdl_st = 0;       // 0 idle, 1 armed, 2 capturing, 3 streaming
   int   mdl_taken = 0;
   int   mdl_vidx = 0;
   int   mdl_decim = 0;
   logic exp_ovf = 1'b0;

   task automatic take(input logic [DW-1:0] d);
      exp_wr_q.push_back({AW'(mdl_taken), d});
      exp_q.push_back({logic'(mdl_taken == FL - 1), d});
      mdl_taken++;
      if (mdl_taken == FL) mdl_st = 3;
   endtask

   task automatic model_sample(input logic [DW-1:0] d, input logic t);
      case (mdl_st)
         1: if (t) begin
               mdl_st = 2;
               mdl_vidx = 0;
               take(d);
            end
         2: begin
               mdl_vidx++;
               if (mdl_vidx % (mdl_decim + 1) == 0) take(d);
            end
         3: exp_ovf = 1'b1;
         default: ;
      endcase
   endtask

   // ---------------- drivers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [DW-1:0] d, input logic t, input int gap);
      adc_valid = 1'b1;
      adc_data  = d;
      trig      = t;
      model_sample(d, t);
      tick();
      adc_valid = 1'b0;
      repeat (gap) tick();
   endtask

   task automatic pulse_start();
      start = 1'b1;
      if (mdl_st == 0) begin
         mdl_st = 1;
         mdl_taken = 0;
         exp_ovf = 1'b0;
      end
      tick();
      start = 1'b0;
   endtask

   task automatic do_abort();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      exp_q.delete();
      exp_wr_q.delete();
      mdl_st = 0;
   endtask

   task automatic wait_frame(input int budget);
      int n = 0;
      while (!(exp_q.size() == 0 && dbg_state == IDLE) && n < budget) begin
         tick();
         n++;
      end
      if (n >= budget) begin
         total++;
         bad++;
         $display("FAIL frame_timeout: waited=%0d cycles limit=%0d left=%0d", n, budget, exp_q.size());
         exp_q.delete();
         exp_wr_q.delete();
      end
      mdl_st = 0;
   endtask

   task automatic check_reset_outputs();
      check("rst_cea",   ram_cea, 0);
      check("rst_ada",   ram_ada, 0);
      check("rst_din",   ram_din, 0);
      check("rst_ceb",   ram_ceb, 0);
      check("rst_adb",   ram_adb, 0);
      check("rst_oce",   ram_oce, 1);
      check("rst_valid", m_valid, 0);
      check("rst_data",  m_data, 0);
      check("rst_last",  m_last, 0);
      check("rst_busy",  busy, 0);
      check("rst_done",  done, 0);
      check("rst_ovf",   ovf, 0);
      check("rst_state", dbg_state, IDLE);
   endtask

   // ---------------- consumer ready ----------------
   int rdy_mode = 1;   // 1: always ready, 0: random 50%
   initial forever begin
      @(posedge clk);
      #1;
      m_ready = (rdy_mode != 0) ? 1'b1 : 1'($urandom_range(0, 1));
   end

   // ---------------- monitor ----------------
   int          beats = 0;
   int          b2b = 0;
   int          done_cnt = 0;
   logic        prev_hs = 1'b0;
   logic        hold_v = 1'b0;
   logic [DW:0] hold_d = '0;
   logic        next_first = 1'b1;
   logic [DW:0] first_beat = '0;

   always @(negedge clk) begin
      if (rst_n) begin
         if (hold_v) begin
            check("hold_valid", m_valid, 1);
            check("hold_data", {m_last, m_data}, hold_d);
         end
         hold_v = m_valid && !m_ready && !abort;
         hold_d = {m_last, m_data};
         if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL extra_beat: got=%0h expected=none", {m_last, m_data});
            end else begin
               check("beat", {m_last, m_data}, exp_q.pop_front());
            end
            if (next_first) first_beat = {m_last, m_data};
            next_first = m_last;
            beats++;
            if (prev_hs) b2b++;
         end
         prev_hs = m_valid && m_ready;
         if (abort) next_first = 1'b1;
         if (done) done_cnt++;
         if (ram_cea) begin
            if (exp_wr_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL extra_write: got addr=%0h data=%0h expected=none", ram_ada, ram_din);
            end else begin
               check("bram_write", {ram_ada, ram_din}, exp_wr_q.pop_front());
            end
         end
      end else begin
         hold_v = 1'b0;
         prev_hs = 1'b0;
         next_first = 1'b1;
      end
   end

   // ---------------- test sequence ----------------
   initial begin
      int d0, b0, bb0;
      logic mv_seen;

      repeat (3) tick();
      check_reset_outputs();
      rst_n = 1'b1;
      tick();

      // full frame at full rate, ramp data
      rdy_mode = 1;
      d0 = done_cnt; b0 = beats; bb0 = b2b;
      pulse_start();
      check("busy_armed", busy, 1);
      for (int i = 0; i < FL; i++) send(DW'(i), 1'b1, 0);
      wait_frame(5000);
      check("full_beats", beats - b0, FL);
      check("full_b2b_ge_1000", (b2b - bb0) >= 1000, 1);
      check("full_done", done_cnt - d0, 1);
      check("full_ovf", ovf, exp_ovf);

      // random backpressure, random data and gaps
      rdy_mode = 0;
      d0 = done_cnt; b0 = beats;
      pulse_start();
      for (int i = 0; i < FL; i++) send(DW'($urandom), 1'b1, $urandom_range(0, 1));
      wait_frame(20000);
      check("bp_beats", beats - b0, FL);
      check("bp_done", done_cnt - d0, 1);

      // trigger gating
      rdy_mode = 1;
      d0 = done_cnt;
      pulse_start();
      for (int i = 0; i < 20; i++) send(DW'($urandom_range(0, 16'h7fff)), 1'b0, 0);
      send(16'hA5A5, 1'b1, 0);
      for (int i = 1; i < FL; i++) send(DW'($urandom), 1'($urandom_range(0, 1)), 0);
      wait_frame(5000);
      check("trig_addr0", mem[0], 16'hA5A5);
      check("trig_first_beat", first_beat, {1'b0, 16'hA5A5});
      check("trig_done", done_cnt - d0, 1);

      // abort after 300 writes
      d0 = done_cnt;
      pulse_start();
      for (int i = 0; i < 300; i++) send(DW'($urandom), 1'b1, 0);
      do_abort();
      check("abort_busy", busy, 0);
      check("abort_state", dbg_state, IDLE);
      check("abort_cea", ram_cea, 0);
      check("abort_ceb", ram_ceb, 0);
      mv_seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (m_valid) mv_seen = 1'b1;
         tick();
      end
      check("abort_no_valid", mv_seen, 0);
      check("abort_no_done", done_cnt - d0, 0);

      // overflow: samples arriving while streaming
      b0 = beats;
      pulse_start();
      for (int i = 0; i < FL; i++) send(DW'($urandom), 1'b1, 0);
      for (int i = 0; i < 3; i++) send(DW'($urandom), 1'b1, 0);
      wait_frame(5000);
      check("ovf_set", ovf, exp_ovf);
      check("ovf_beats", beats - b0, FL);
      pulse_start();
      check("ovf_cleared", ovf, exp_ovf);
      check("restart_busy", busy, 1);
      do_abort();
      check("idle_after_abort", busy, 0);

      // asynchronous reset mid-capture, then a normal frame
      pulse_start();
      for (int i = 0; i < 100; i++) send(DW'($urandom), 1'b1, 0);
      rst_n = 1'b0;
      #2;
      check_reset_outputs();
      exp_q.delete();
      exp_wr_q.delete();
      mdl_st = 0;
      exp_ovf = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      rdy_mode = 0;
      d0 = done_cnt; b0 = beats;
      pulse_start();
      for (int i = 0; i < FL; i++) send(DW'($urandom), 1'b1, 0);
      wait_frame(20000);
      check("post_rst_beats", beats - b0, FL);
      check("post_rst_done", done_cnt - d0, 1);

`ifdef ADC_BUF_DECIM_EN
      // decimation by 4 on a ramp
      rdy_mode = 1;
      decim = 4'd3;
      mdl_decim = 3;
      d0 = done_cnt; b0 = beats;
      pulse_start();
      for (int i = 0; i <= 4 * (FL - 1); i++) send(DW'(i), 1'b1, 0);
      wait_frame(5000);
      check("decim_beats", beats - b0, FL);
      check("decim_done", done_cnt - d0, 1);
      check("decim_last_word", mem[FL-1], DW'(4 * (FL - 1)));
      decim = 4'd0;
      mdl_decim = 0;
`endif

      repeat (5) tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
